// File: rtl/pulse_req_tx.sv
// rtl/pulse_req_tx.sv - pulse to 4-phase req/ack handshake transmitter
//
// Turns single-cycle event pulses in the clk domain into a 4-phase req/ack
// handshake toward an unrelated clock domain. One event may be queued behind
// the handshake in flight; further events are dropped and counted.
//
// Parameters:
//   SYNC_STAGES  flops in the ack_in synchronizer chain (2..4)
//   DROP_W       width of drop_cnt (saturating)
// Ports:
//   clk       in   clock, all state updates on posedge
//   rst_n     in   asynchronous active-low reset
//   pulse_in  in   event strobe, clk-synchronous
//   ack_in    in   acknowledge from far domain, asynchronous to clk
//   req_out   out  registered request level to far domain
//   busy      out  1 whenever a handshake is in progress
//   pending   out  one event queued behind the current handshake
//   done      out  1-cycle pulse: handshake completed
//   drop      out  1-cycle pulse: an event was lost
//   drop_cnt  out  saturating count of dropped events
module pulse_req_tx #(
   parameter int SYNC_STAGES = 2,
   parameter int DROP_W      = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pulse_in,
   input  logic              ack_in,
   output logic              req_out,
   output logic              busy,
   output logic              pending,
   output logic              done,
   output logic              drop,
   output logic [DROP_W-1:0] drop_cnt
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_REL  = 2'd2
   } state_t;

   localparam logic [DROP_W-1:0] CNT_ONE = {{(DROP_W-1){1'b0}}, 1'b1};
   localparam logic [DROP_W-1:0] CNT_MAX = {DROP_W{1'b1}};

   state_t                  state;
   state_t                  state_nxt;
   logic [SYNC_STAGES-1:0]  ack_sync;
   logic                    ack_s;
   logic                    rel_exit;
   logic                    req_nxt;
   logic                    pending_nxt;
   logic                    done_nxt;
   logic                    drop_nxt;
   logic [DROP_W-1:0]       cnt_nxt;

   // ack_in is asynchronous; only the last stage is used by the FSM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack_sync <= '0;
      end else begin
         ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack_in};
      end
   end

   assign ack_s = ack_sync[SYNC_STAGES-1];

   // State register; the visible outputs are registered alongside it so that
   // req_out toward the far domain is a clean flop output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         req_out  <= 1'b0;
         pending  <= 1'b0;
         done     <= 1'b0;
         drop     <= 1'b0;
         drop_cnt <= '0;
      end else begin
         state    <= state_nxt;
         req_out  <= req_nxt;
         pending  <= pending_nxt;
         done     <= done_nxt;
         drop     <= drop_nxt;
         drop_cnt <= cnt_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (pulse_in) state_nxt = S_REQ;
         S_REQ:  if (ack_s) state_nxt = S_REL;
         S_REL:  if (!ack_s) state_nxt = (pending || pulse_in) ? S_REQ : S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   assign rel_exit = (state == S_REL) && !ack_s;
   assign busy     = (state != S_IDLE);

   // Output / queue logic
   always_comb begin
      req_nxt     = (state_nxt == S_REQ);
      done_nxt    = rel_exit;
      pending_nxt = pending;
      drop_nxt    = 1'b0;
      cnt_nxt     = drop_cnt;
      if (rel_exit) begin
         // A queued event starts the new REQ; a simultaneous pulse takes its
         // place in the queue. Without a queued event the pulse starts REQ.
         pending_nxt = pending && pulse_in;
      end else if ((state != S_IDLE) && pulse_in) begin
         if (!pending) begin
            pending_nxt = 1'b1;
         end else begin
            drop_nxt = 1'b1;
            if (drop_cnt != CNT_MAX) cnt_nxt = drop_cnt + CNT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_pulse_req_tx.sv
// tb/tb_pulse_req_tx.sv - self-checking bench for pulse_req_tx
module tb_pulse_req_tx;

   localparam int HS_LEN = 10;   // start edge to done edge with this bench's responder

   logic       clk;
   logic       rst_n;
   logic       pulse_in;
   logic       ack_in;
   logic       req_out;
   logic       busy;
   logic       pending;
   logic       done;
   logic       drop;
   logic [1:0] drop_cnt;

   int errors;
   int checks;
   int n_done;
   int n_drop;
   int n_rise;
   logic req_prev;
   logic [2:0] hist;

   pulse_req_tx #(.SYNC_STAGES(2), .DROP_W(2)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .pulse_in (pulse_in),
      .ack_in   (ack_in),
      .req_out  (req_out),
      .busy     (busy),
      .pending  (pending),
      .done     (done),
      .drop     (drop),
      .drop_cnt (drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Far-side responder: ack_in follows req_out about 3 clocks later, off-phase.
   initial hist = 3'b000;
   always @(negedge clk) begin
      hist = {hist[1:0], req_out};
      #2 ack_in = hist[2];
   end

   // Event monitors
   always @(negedge clk) begin
      if (rst_n) begin
         if (done) n_done++;
         if (drop) n_drop++;
         if (req_out && !req_prev) n_rise++;
      end
      req_prev = req_out;
   end

   task automatic tick(input logic p);
      pulse_in = p;
      @(posedge clk);
      #1;
      pulse_in = 1'b0;
   endtask

   task automatic do_reset();
      pulse_in = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (12) tick(1'b0);
      n_done = 0;
      n_drop = 0;
      n_rise = 0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({req_out, busy, pending, done, drop, drop_cnt} !== 7'b0) begin
         errors++;
         $display("FAIL reset_idle: got %b want 0000000", {req_out, busy, pending, done, drop, drop_cnt});
      end
      tick(1'b1);
      tick(1'b1);
      tick(1'b1);
      checks++;
      if ({req_out, busy, pending, drop_cnt} !== 5'b11101) begin
         errors++;
         $display("FAIL reset_pre: got %b want 11101", {req_out, busy, pending, drop_cnt});
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({req_out, busy, pending, done, drop, drop_cnt} !== 7'b0) begin
         errors++;
         $display("FAIL reset_async: got %b want 0000000", {req_out, busy, pending, done, drop, drop_cnt});
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      tick(1'b0);
      checks++;
      if ({req_out, busy, pending} !== 3'b000) begin
         errors++;
         $display("FAIL reset_release: got %b want 000", {req_out, busy, pending});
      end
   endtask

   task automatic test_single();
      do_reset();
      for (int i = 0; i <= 30; i++) begin
         tick(i == 10);
         if (i == 10) begin
            checks++;
            if (req_out !== 1'b1) begin
               errors++;
               $display("FAIL single_latency: req_out=%b want 1", req_out);
            end
         end
         if (i == 14 || i == 15) begin
            checks++;
            if (req_out !== (i == 14)) begin
               errors++;
               $display("FAIL single_req_fall@%0d: req_out=%b want %b", i, req_out, i == 14);
            end
         end
         if (i == 20) begin
            checks++;
            if (done !== 1'b1) begin
               errors++;
               $display("FAIL single_done_cycle: done=%b want 1", done);
            end
         end
      end
      checks++;
      if (n_done !== 1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL single_end: done_count=%0d busy=%b want 1 0", n_done, busy);
      end
   endtask

   task automatic test_pending();
      do_reset();
      for (int i = 0; i <= 40; i++) begin
         tick(i == 10 || i == 12);
         if (i == 12) begin
            checks++;
            if (pending !== 1'b1) begin
               errors++;
               $display("FAIL pend_set: pending=%b want 1", pending);
            end
         end
         if (i == 20) begin
            checks++;
            if ({done, req_out, pending} !== 3'b110) begin
               errors++;
               $display("FAIL pend_restart: done,req,pend=%b want 110", {done, req_out, pending});
            end
         end
      end
      checks++;
      if (n_rise !== 2 || n_done !== 2 || drop_cnt !== 2'd0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL pend_totals: hs=%0d done=%0d cnt=%0d busy=%b want 2 2 0 0", n_rise, n_done, drop_cnt, busy);
      end
   endtask

   task automatic test_drop();
      do_reset();
      for (int i = 0; i <= 40; i++) begin
         tick(i == 10 || i == 12 || i == 14);
         if (i == 14) begin
            checks++;
            if (drop !== 1'b1) begin
               errors++;
               $display("FAIL drop_pulse: drop=%b want 1", drop);
            end
         end
      end
      checks++;
      if (n_rise !== 2 || n_done !== 2 || drop_cnt !== 2'd1 || n_drop !== 1) begin
         errors++;
         $display("FAIL drop_totals: hs=%0d done=%0d cnt=%0d drops=%0d want 2 2 1 1", n_rise, n_done, drop_cnt, n_drop);
      end
   endtask

   task automatic test_saturate();
      do_reset();
      for (int i = 0; i <= 35; i++) begin
         tick(i <= 7);
         if (i == 4) begin
            checks++;
            if (drop_cnt !== 2'd3) begin
               errors++;
               $display("FAIL sat_reach: drop_cnt=%0d want 3", drop_cnt);
            end
         end
      end
      checks++;
      if (drop_cnt !== 2'd3 || n_drop !== 6 || n_rise !== 2) begin
         errors++;
         $display("FAIL sat_totals: cnt=%0d drops=%0d hs=%0d want 3 6 2", drop_cnt, n_drop, n_rise);
      end
   endtask

   task automatic test_exit_edge();
      do_reset();
      for (int i = 0; i <= 45; i++) begin
         tick(i == 0 || i == 2 || i == 10);
         if (i == 10) begin
            checks++;
            if ({done, req_out, pending, drop} !== 4'b1110) begin
               errors++;
               $display("FAIL exit_edge: done,req,pend,drop=%b want 1110", {done, req_out, pending, drop});
            end
         end
      end
      checks++;
      if (n_rise !== 3 || n_done !== 3 || n_drop !== 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL exit_totals: hs=%0d done=%0d drops=%0d busy=%b want 3 3 0 0", n_rise, n_done, n_drop, busy);
      end
   endtask

   // Random pulses against a ticket model: every accepted event owns an
   // HS_LEN-cycle slot that starts when the previous one finishes; at most two
   // unfinished events (active + queued) may exist when a pulse arrives.
   task automatic test_random();
      int st[$];
      int cp[$];
      int drops;
      int outstanding;
      int s;
      logic p;
      logic dk;
      logic e_req, e_busy, e_pend, e_done;
      logic [1:0] e_cnt;
      do_reset();
      drops = 0;
      for (int k = 0; k < 400; k++) begin
         p = ($urandom_range(3) == 0);
         dk = 1'b0;
         if (p) begin
            outstanding = 0;
            foreach (cp[j]) if (cp[j] > k) outstanding++;
            if (outstanding < 2) begin
               s = k;
               if (cp.size() > 0 && cp[$] > k) s = cp[$];
               st.push_back(s);
               cp.push_back(s + HS_LEN);
            end else begin
               drops++;
               dk = 1'b1;
            end
         end
         tick(p);
         e_req = 0; e_busy = 0; e_pend = 0; e_done = 0;
         foreach (st[j]) begin
            if (st[j] <= k && k < st[j] + HS_LEN / 2) e_req = 1;
            if (st[j] <= k && k < cp[j]) e_busy = 1;
            if (st[j] > k) e_pend = 1;
            if (cp[j] == k) e_done = 1;
         end
         e_cnt = (drops > 3) ? 2'd3 : 2'(drops);
         checks++;
         if ({req_out, busy, pending, done, drop, drop_cnt} !== {e_req, e_busy, e_pend, e_done, dk, e_cnt}) begin
            errors++;
            $display("FAIL random@%0d: req,busy,pend,done,drop,cnt=%b want %b", k,
                     {req_out, busy, pending, done, drop, drop_cnt}, {e_req, e_busy, e_pend, e_done, dk, e_cnt});
         end
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      n_done = 0;
      n_drop = 0;
      n_rise = 0;
      req_prev = 1'b0;
      ack_in = 1'b0;
      pulse_in = 1'b0;
      rst_n = 1'b0;
      test_reset();
      test_single();
      test_pending();
      test_drop();
      test_saturate();
      test_exit_edge();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
